// File: rtl/dmem_bank_responder_if.sv
// Byte-wide bank bus between the CPU-side data-memory decoder (master)
// and one per-die bank responder (slave).
interface dmem_bank_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              ce_mem;
    logic              we_mem;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        inter_dmem;
    logic              rvalid;
    logic              ready;

    modport master (
        output ce_mem, we_mem, mem_addr, mem_wdata,
        input  inter_dmem, rvalid, ready
    );

    modport slave (
        input  ce_mem, we_mem, mem_addr, mem_wdata,
        output inter_dmem, rvalid, ready
    );
endinterface

// File: rtl/dmem_bank_responder.sv
// Per-die data-memory bank: scrubs its array to RESET_VAL after reset, then
// serves one read or write per cycle with registered, held read data.
module dmem_bank_responder #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_bank_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [7:0]        inter_dmem_q, inter_dmem_d;
    logic              rvalid_q, rvalid_d;
    logic              ready_q, ready_d;

    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wbyte;

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        inter_dmem_d = inter_dmem_q;
        rvalid_d     = 1'b0;
        ready_d      = ready_q;
        mem_we       = 1'b0;
        mem_waddr    = bus.mem_addr;
        mem_wbyte    = bus.mem_wdata;

        unique case (state_q)
            ST_INIT: begin
                // Bus requests are deliberately ignored until the scrub ends.
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wbyte  = RESET_VAL;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (&init_cnt_q) begin
                    state_d = ST_SERVE;
                    ready_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (bus.ce_mem) begin
                    if (bus.we_mem) begin
                        mem_we = 1'b1;
                    end else begin
                        inter_dmem_d = mem[bus.mem_addr];
                        rvalid_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            inter_dmem_q <= 8'h00;
            rvalid_q     <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            inter_dmem_q <= inter_dmem_d;
            rvalid_q     <= rvalid_d;
            ready_q      <= ready_d;
        end
    end

    // NOTE: the array has no reset term so it maps onto plain RAM; its
    // contents are cleared by the INIT scrub instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wbyte;
        end
    end

    assign bus.inter_dmem = inter_dmem_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.ready      = ready_q;
endmodule
